rs_alu: RTL and testbench
=========================

RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 4, number of reservation-station entries (power of two, 2..8).
REQ-002 SHALL use widths `PC_WIDTH, `WORD_WIDTH, `DATA_WIDTH_ALU_OP and RW = $clog2(`ROB_DEPTH).
REQ-003 SHALL have a single clock; reset is asynchronous and active-low. Ports are clk (in, 1) and rst_n (in, 1).
REQ-004 SHALL have port cpu_en (in, 1): global enable. When 0, all state holds.
REQ-005 SHALL have port rs_flush (in, 1): discards all entries and the issue register.
REQ-006 SHALL have dispatch ports disp_valid (in, 1), disp_pc (in, PC), disp_alu_op (in, ALU_OP), disp_imm (in, WORD) and disp_rob (in, RW): one ALU instruction from the ID-stage register.
REQ-007 SHALL have, per source x in {1,2}: disp_rsx_rat_valid (in, 1), disp_rsx_Paddr (in, RW) and disp_rsx_value (in, WORD). rat_valid=1 means the value is pending on producer ROB tag Paddr. rat_valid=0 means value holds the GPR value.
REQ-008 SHALL have CDB ports cdb_valid (in, 1), cdb_rob (in, RW) and cdb_value (in, WORD): one result broadcast per cycle.
REQ-009 SHALL have port rs_full (out, 1): all entries valid. It drives upstream id_stall.
REQ-010 SHALL have issue ports issue_valid (out, 1), issue_pc, issue_alu_op, issue_imm, issue_rob, issue_src1 and issue_src2 (out, WORD): registered issue to the ALU.

Function
REQ-011 SHALL store per entry: valid, pc, alu_op, imm, rob, and for each source a ready bit, tag (RW) and value (WORD).
REQ-012 SHALL drive rs_full combinationally from the entry valid bits only.
REQ-013 SHALL accept a dispatch on an edge with cpu_en=1, rs_flush=0, disp_valid=1 and rs_full=0. The instruction is written into the lowest-index entry that is invalid at the start of the cycle.
REQ-014 SHALL ignore disp_valid while rs_full=1, with no state change. Upstream holds the instruction.
REQ-015 SHALL capture each source at dispatch as follows:
- rat_valid=0: ready, with disp value.
- rat_valid=1, cdb_valid=1 and cdb_rob==Paddr: ready, with cdb_value (same-cycle bypass).
- Otherwise: not ready, with tag=Paddr.
REQ-016 SHALL wake up, every enabled cycle with cdb_valid=1, each valid entry's non-ready source whose tag==cdb_rob: it becomes ready with value=cdb_value. All matching entries and both sources wake simultaneously.
REQ-017 SHALL select, each enabled cycle, the lowest-index entry that is valid with both sources ready, using registered state only. An entry woken this cycle is selectable next cycle.
REQ-018 SHALL, on an edge with a selected entry, load the issue registers from it, set issue_valid=1 and clear that entry's valid. With no selection, issue_valid=0 at that edge.
REQ-019 SHALL set issue_src1/issue_src2 from the entry source values. issue_imm passes through unaltered; operand choice belongs to the ALU.
REQ-020 SHALL allow dispatch and issue on the same edge. The issued entry is not reused by that cycle's dispatch. rs_full is deasserted after the edge.
REQ-021 SHALL give latency as follows: dispatch with both sources ready at edge N gives issue_valid=1 after edge N+1. A CDB wakeup at edge N gives issue after edge N+1.
REQ-022 SHALL give rs_flush (with cpu_en=1) priority over dispatch, wakeup and issue. At the edge all entries become invalid and issue_valid=0.
REQ-023 SHALL hold all registers, including issue_valid, when cpu_en=0, regardless of other inputs.
REQ-024 SHALL not check duplicate ROB tags. Tags are unique by construction.

Reset
REQ-025 SHALL, when rst_n=0, asynchronously clear all entry valid, ready, tag and value fields and all issue_* outputs to 0. rs_full=0.
REQ-026 SHALL, when reset is asserted mid-operation, discard all pending entries. There is no partial-issue state after release.

Verification
REQ-027 Reset: after rst_n release with disp_valid=0 -> issue_valid=0, rs_full=0 and all issue_* outputs 0.
REQ-028 Ready dispatch: op=ADD, rs1 value 5, rs2 value 7, rob=3, both rat_valid=0 at edge N -> after N+1, issue_valid=1, src1=5, src2=7, issue_rob=3.
REQ-029 Wakeup and bypass:
- Entry A waits on tag 2. CDB broadcasts tag 2, value 0xAA -> A issues next edge with src=0xAA.
- Entry B dispatched in the same cycle as the CDB for tag 4 -> B is captured ready.
REQ-030 Full and priority:
- Fill 4 entries all waiting on tag 1 -> rs_full=1 and a 5th disp_valid is ignored.
- CDB tag 1 -> entries issue in order 0,1,2,3 on consecutive edges.
- A dispatch in the first issue cycle lands in entry 0 only after it is freed.
REQ-031 Flush/enable:
- cpu_en=0 with a ready entry -> no issue, state frozen.
- rs_flush with 3 valid entries and issue_valid=1 -> all cleared, rs_full=0 and issue_valid=0 after the edge.

Source files
------------

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ALU ops until both operands are ready,
// snoops the CDB for wakeup and issues the oldest-slot ready entry through a register.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef DATA_WIDTH_ALU_OP
`define DATA_WIDTH_ALU_OP 4
`endif
`ifndef ROB_DEPTH
`define ROB_DEPTH 8
`endif

module rs_alu #(
    parameter int unsigned RS_DEPTH = 4,
    localparam int unsigned RW = $clog2(`ROB_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cpu_en,
    input  logic                          rs_flush,
    input  logic                          disp_valid,
    input  logic [`PC_WIDTH-1:0]          disp_pc,
    input  logic [`DATA_WIDTH_ALU_OP-1:0] disp_alu_op,
    input  logic [`WORD_WIDTH-1:0]        disp_imm,
    input  logic [RW-1:0]                 disp_rob,
    input  logic                          disp_rs1_rat_valid,
    input  logic [RW-1:0]                 disp_rs1_Paddr,
    input  logic [`WORD_WIDTH-1:0]        disp_rs1_value,
    input  logic                          disp_rs2_rat_valid,
    input  logic [RW-1:0]                 disp_rs2_Paddr,
    input  logic [`WORD_WIDTH-1:0]        disp_rs2_value,
    input  logic                          cdb_valid,
    input  logic [RW-1:0]                 cdb_rob,
    input  logic [`WORD_WIDTH-1:0]        cdb_value,
    output logic                          rs_full,
    output logic                          issue_valid,
    output logic [`PC_WIDTH-1:0]          issue_pc,
    output logic [`DATA_WIDTH_ALU_OP-1:0] issue_alu_op,
    output logic [`WORD_WIDTH-1:0]        issue_imm,
    output logic [RW-1:0]                 issue_rob,
    output logic [`WORD_WIDTH-1:0]        issue_src1,
    output logic [`WORD_WIDTH-1:0]        issue_src2
);

    localparam int unsigned PW = `PC_WIDTH;
    localparam int unsigned WW = `WORD_WIDTH;
    localparam int unsigned OW = `DATA_WIDTH_ALU_OP;
    localparam int unsigned IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    logic [RS_DEPTH-1:0] valid_q, valid_d;
    logic [RS_DEPTH-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [PW-1:0]       pc_q   [RS_DEPTH];
    logic [PW-1:0]       pc_d   [RS_DEPTH];
    logic [OW-1:0]       op_q   [RS_DEPTH];
    logic [OW-1:0]       op_d   [RS_DEPTH];
    logic [WW-1:0]       imm_q  [RS_DEPTH];
    logic [WW-1:0]       imm_d  [RS_DEPTH];
    logic [RW-1:0]       rob_q  [RS_DEPTH];
    logic [RW-1:0]       rob_d  [RS_DEPTH];
    logic [RW-1:0]       tag1_q [RS_DEPTH];
    logic [RW-1:0]       tag1_d [RS_DEPTH];
    logic [RW-1:0]       tag2_q [RS_DEPTH];
    logic [RW-1:0]       tag2_d [RS_DEPTH];
    logic [WW-1:0]       val1_q [RS_DEPTH];
    logic [WW-1:0]       val1_d [RS_DEPTH];
    logic [WW-1:0]       val2_q [RS_DEPTH];
    logic [WW-1:0]       val2_d [RS_DEPTH];

    logic          issue_valid_q, issue_valid_d;
    logic [PW-1:0] issue_pc_q, issue_pc_d;
    logic [OW-1:0] issue_op_q, issue_op_d;
    logic [WW-1:0] issue_imm_q, issue_imm_d;
    logic [RW-1:0] issue_rob_q, issue_rob_d;
    logic [WW-1:0] issue_src1_q, issue_src1_d;
    logic [WW-1:0] issue_src2_q, issue_src2_d;

    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] free_idx;
    logic          bypass1, bypass2;

    assign rs_full = &valid_q;

    // Both scans use registered state only; descending loop leaves the lowest index.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
            if (!valid_q[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    assign bypass1 = cdb_valid && (cdb_rob == disp_rs1_Paddr);
    assign bypass2 = cdb_valid && (cdb_rob == disp_rs2_Paddr);

    always_comb begin
        valid_d       = valid_q;
        rdy1_d        = rdy1_q;
        rdy2_d        = rdy2_q;
        pc_d          = pc_q;
        op_d          = op_q;
        imm_d         = imm_q;
        rob_d         = rob_q;
        tag1_d        = tag1_q;
        tag2_d        = tag2_q;
        val1_d        = val1_q;
        val2_d        = val2_q;
        issue_valid_d = issue_valid_q;
        issue_pc_d    = issue_pc_q;
        issue_op_d    = issue_op_q;
        issue_imm_d   = issue_imm_q;
        issue_rob_d   = issue_rob_q;
        issue_src1_d  = issue_src1_q;
        issue_src2_d  = issue_src2_q;

        if (cpu_en) begin
            if (rs_flush) begin
                valid_d       = '0;
                issue_valid_d = 1'b0;
            end else begin
                if (cdb_valid) begin
                    for (int i = 0; i < RS_DEPTH; i++) begin
                        if (valid_q[i] && !rdy1_q[i] && (tag1_q[i] == cdb_rob)) begin
                            rdy1_d[i] = 1'b1;
                            val1_d[i] = cdb_value;
                        end
                        if (valid_q[i] && !rdy2_q[i] && (tag2_q[i] == cdb_rob)) begin
                            rdy2_d[i] = 1'b1;
                            val2_d[i] = cdb_value;
                        end
                    end
                end

                issue_valid_d = sel_found;
                if (sel_found) begin
                    issue_pc_d       = pc_q[sel_idx];
                    issue_op_d       = op_q[sel_idx];
                    issue_imm_d      = imm_q[sel_idx];
                    issue_rob_d      = rob_q[sel_idx];
                    issue_src1_d     = val1_q[sel_idx];
                    issue_src2_d     = val2_q[sel_idx];
                    valid_d[sel_idx] = 1'b0;
                end

                // free_idx points at a slot invalid before this edge, never the issued one.
                if (disp_valid && !rs_full) begin
                    valid_d[free_idx] = 1'b1;
                    pc_d[free_idx]    = disp_pc;
                    op_d[free_idx]    = disp_alu_op;
                    imm_d[free_idx]   = disp_imm;
                    rob_d[free_idx]   = disp_rob;
                    tag1_d[free_idx]  = disp_rs1_Paddr;
                    tag2_d[free_idx]  = disp_rs2_Paddr;
                    rdy1_d[free_idx]  = !disp_rs1_rat_valid || bypass1;
                    rdy2_d[free_idx]  = !disp_rs2_rat_valid || bypass2;
                    val1_d[free_idx]  = (disp_rs1_rat_valid && bypass1) ? cdb_value
                                                                        : disp_rs1_value;
                    val2_d[free_idx]  = (disp_rs2_rat_valid && bypass2) ? cdb_value
                                                                        : disp_rs2_value;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            rdy1_q        <= '0;
            rdy2_q        <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                pc_q[i]   <= '0;
                op_q[i]   <= '0;
                imm_q[i]  <= '0;
                rob_q[i]  <= '0;
                tag1_q[i] <= '0;
                tag2_q[i] <= '0;
                val1_q[i] <= '0;
                val2_q[i] <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_pc_q    <= '0;
            issue_op_q    <= '0;
            issue_imm_q   <= '0;
            issue_rob_q   <= '0;
            issue_src1_q  <= '0;
            issue_src2_q  <= '0;
        end else begin
            valid_q       <= valid_d;
            rdy1_q        <= rdy1_d;
            rdy2_q        <= rdy2_d;
            pc_q          <= pc_d;
            op_q          <= op_d;
            imm_q         <= imm_d;
            rob_q         <= rob_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
            val1_q        <= val1_d;
            val2_q        <= val2_d;
            issue_valid_q <= issue_valid_d;
            issue_pc_q    <= issue_pc_d;
            issue_op_q    <= issue_op_d;
            issue_imm_q   <= issue_imm_d;
            issue_rob_q   <= issue_rob_d;
            issue_src1_q  <= issue_src1_d;
            issue_src2_q  <= issue_src2_d;
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_pc     = issue_pc_q;
    assign issue_alu_op = issue_op_q;
    assign issue_imm    = issue_imm_q;
    assign issue_rob    = issue_rob_q;
    assign issue_src1   = issue_src1_q;
    assign issue_src2   = issue_src2_q;

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: reset, dispatch/issue latency, wakeup, bypass, full, enable, flush.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef DATA_WIDTH_ALU_OP
`define DATA_WIDTH_ALU_OP 4
`endif
`ifndef ROB_DEPTH
`define ROB_DEPTH 8
`endif

module tb_rs_alu;

    localparam int unsigned RW = $clog2(`ROB_DEPTH);

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          cpu_en;
    logic                          rs_flush;
    logic                          disp_valid;
    logic [`PC_WIDTH-1:0]          disp_pc;
    logic [`DATA_WIDTH_ALU_OP-1:0] disp_alu_op;
    logic [`WORD_WIDTH-1:0]        disp_imm;
    logic [RW-1:0]                 disp_rob;
    logic                          disp_rs1_rat_valid;
    logic [RW-1:0]                 disp_rs1_Paddr;
    logic [`WORD_WIDTH-1:0]        disp_rs1_value;
    logic                          disp_rs2_rat_valid;
    logic [RW-1:0]                 disp_rs2_Paddr;
    logic [`WORD_WIDTH-1:0]        disp_rs2_value;
    logic                          cdb_valid;
    logic [RW-1:0]                 cdb_rob;
    logic [`WORD_WIDTH-1:0]        cdb_value;
    logic                          rs_full;
    logic                          issue_valid;
    logic [`PC_WIDTH-1:0]          issue_pc;
    logic [`DATA_WIDTH_ALU_OP-1:0] issue_alu_op;
    logic [`WORD_WIDTH-1:0]        issue_imm;
    logic [RW-1:0]                 issue_rob;
    logic [`WORD_WIDTH-1:0]        issue_src1;
    logic [`WORD_WIDTH-1:0]        issue_src2;

    int checks = 0;
    int errors = 0;

    rs_alu #(.RS_DEPTH(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cpu_en             (cpu_en),
        .rs_flush           (rs_flush),
        .disp_valid         (disp_valid),
        .disp_pc            (disp_pc),
        .disp_alu_op        (disp_alu_op),
        .disp_imm           (disp_imm),
        .disp_rob           (disp_rob),
        .disp_rs1_rat_valid (disp_rs1_rat_valid),
        .disp_rs1_Paddr     (disp_rs1_Paddr),
        .disp_rs1_value     (disp_rs1_value),
        .disp_rs2_rat_valid (disp_rs2_rat_valid),
        .disp_rs2_Paddr     (disp_rs2_Paddr),
        .disp_rs2_value     (disp_rs2_value),
        .cdb_valid          (cdb_valid),
        .cdb_rob            (cdb_rob),
        .cdb_value          (cdb_value),
        .rs_full            (rs_full),
        .issue_valid        (issue_valid),
        .issue_pc           (issue_pc),
        .issue_alu_op       (issue_alu_op),
        .issue_imm          (issue_imm),
        .issue_rob          (issue_rob),
        .issue_src1         (issue_src1),
        .issue_src2         (issue_src2)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [31:0] pc, input logic [3:0] op, input logic [31:0] imm,
                            input logic [RW-1:0] rob,
                            input logic r1p, input logic [RW-1:0] t1, input logic [31:0] v1,
                            input logic r2p, input logic [RW-1:0] t2, input logic [31:0] v2);
        disp_valid         = 1'b1;
        disp_pc            = pc;
        disp_alu_op        = op;
        disp_imm           = imm;
        disp_rob           = rob;
        disp_rs1_rat_valid = r1p;
        disp_rs1_Paddr     = t1;
        disp_rs1_value     = v1;
        disp_rs2_rat_valid = r2p;
        disp_rs2_Paddr     = t2;
        disp_rs2_value     = v2;
    endtask

    task automatic set_cdb(input logic v, input logic [RW-1:0] tag, input logic [31:0] val);
        cdb_valid = v;
        cdb_rob   = tag;
        cdb_value = val;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_en = 1'b1; rs_flush = 1'b0;
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        disp_valid = 1'b0;
        set_cdb(0, 0, 0);
        #23 rst_n = 1'b1;
        step();
        checks++; if (issue_valid !== 1'b0) begin errors++;
            $display("FAIL reset_issue_valid: got %0b want 0", issue_valid); end
        checks++; if (rs_full !== 1'b0) begin errors++;
            $display("FAIL reset_rs_full: got %0b want 0", rs_full); end
        checks++; if ({issue_pc, issue_alu_op, issue_imm, issue_rob, issue_src1, issue_src2} !== '0)
            begin errors++;
            $display("FAIL reset_issue_fields: pc=%0h op=%0h imm=%0h rob=%0h s1=%0h s2=%0h want 0",
                     issue_pc, issue_alu_op, issue_imm, issue_rob, issue_src1, issue_src2); end
    endtask

    task automatic test_ready_dispatch();
        set_disp(32'h100, 4'h0, 32'h11, 3, 0, 0, 5, 0, 0, 7);
        step();
        disp_valid = 1'b0;
        checks++; if (issue_valid !== 1'b0) begin errors++;
            $display("FAIL ready_early_issue: got %0b want 0", issue_valid); end
        step();
        checks++; if (issue_valid !== 1'b1) begin errors++;
            $display("FAIL ready_issue_valid: got %0b want 1", issue_valid); end
        checks++; if (issue_src1 !== 32'd5 || issue_src2 !== 32'd7) begin errors++;
            $display("FAIL ready_srcs: got %0d/%0d want 5/7", issue_src1, issue_src2); end
        checks++; if (issue_rob !== 3'd3 || issue_pc !== 32'h100) begin errors++;
            $display("FAIL ready_rob_pc: got %0d/%0h want 3/100", issue_rob, issue_pc); end
        checks++; if (issue_imm !== 32'h11 || issue_alu_op !== 4'h0) begin errors++;
            $display("FAIL ready_imm_op: got %0h/%0h want 11/0", issue_imm, issue_alu_op); end
        step();
        checks++; if (issue_valid !== 1'b0) begin errors++;
            $display("FAIL ready_single_issue: got %0b want 0", issue_valid); end
    endtask

    task automatic test_wakeup_bypass();
        set_disp(32'h200, 4'h1, 32'h0, 5, 1, 2, 32'hDEAD, 0, 0, 3);
        step();
        disp_valid = 1'b0;
        set_cdb(1, 6, 32'h99);
        step();
        set_cdb(0, 0, 0);
        checks++; if (issue_valid !== 1'b0) begin errors++;
            $display("FAIL wake_waiting_no_issue: got %0b want 0", issue_valid); end
        set_cdb(1, 2, 32'hAA);
        step();
        set_cdb(0, 0, 0);
        checks++; if (issue_valid !== 1'b0) begin errors++;
            $display("FAIL wake_same_edge_issue: got %0b want 0", issue_valid); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rob !== 3'd5) begin errors++;
            $display("FAIL wake_issue: valid=%0b rob=%0d want 1/5", issue_valid, issue_rob); end
        checks++; if (issue_src1 !== 32'hAA || issue_src2 !== 32'd3) begin errors++;
            $display("FAIL wake_srcs: got %0h/%0h want aa/3", issue_src1, issue_src2); end
        set_disp(32'h240, 4'h2, 32'h0, 6, 1, 4, 32'h1, 1, 4, 32'h2);
        set_cdb(1, 4, 32'h55);
        step();
        disp_valid = 1'b0;
        set_cdb(0, 0, 0);
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rob !== 3'd6) begin errors++;
            $display("FAIL bypass_issue: valid=%0b rob=%0d want 1/6", issue_valid, issue_rob); end
        checks++; if (issue_src1 !== 32'h55 || issue_src2 !== 32'h55) begin errors++;
            $display("FAIL bypass_srcs: got %0h/%0h want 55/55", issue_src1, issue_src2); end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            set_disp(32'h300 + i, 4'h3, 0, RW'(i + 1), 0, 0, i, 0, 0, 10 + i);
            step();
            if (i > 0) begin
                checks++; if (issue_valid !== 1'b1 || issue_rob !== RW'(i)) begin errors++;
                    $display("FAIL b2b_issue_%0d: valid=%0b rob=%0d want 1/%0d",
                             i, issue_valid, issue_rob, i); end
            end
        end
        disp_valid = 1'b0;
        step();
        checks++; if (issue_valid !== 1'b1 || issue_src2 !== 32'd12) begin errors++;
            $display("FAIL b2b_last: valid=%0b s2=%0d want 1/12", issue_valid, issue_src2); end
        step();
        checks++; if (issue_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_drain: got %0b want 0", issue_valid); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            set_disp(32'h400 + i, 4'h4, 0, RW'(4 + i), 1, 1, 0, 0, 0, i);
            step();
        end
        checks++; if (rs_full !== 1'b1) begin errors++;
            $display("FAIL full_asserted: got %0b want 1", rs_full); end
        set_disp(32'h500, 4'h5, 0, 2, 1, 3, 0, 0, 0, 32'h22);
        step();
        checks++; if (rs_full !== 1'b1 || issue_valid !== 1'b0) begin errors++;
            $display("FAIL full_ignore: full=%0b valid=%0b want 1/0", rs_full, issue_valid); end
        set_cdb(1, 1, 32'h10);
        step();
        set_cdb(0, 0, 0);
        checks++; if (rs_full !== 1'b1 || issue_valid !== 1'b0) begin errors++;
            $display("FAIL full_wake_edge: full=%0b valid=%0b want 1/0", rs_full, issue_valid); end
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rob !== 3'd4 || rs_full !== 1'b0) begin
            errors++;
            $display("FAIL full_issue0: valid=%0b rob=%0d full=%0b want 1/4/0",
                     issue_valid, issue_rob, rs_full); end
        checks++; if (issue_src1 !== 32'h10 || issue_src2 !== 32'd0) begin errors++;
            $display("FAIL full_issue0_srcs: got %0h/%0h want 10/0", issue_src1, issue_src2); end
        step();
        disp_valid = 1'b0;
        checks++; if (issue_valid !== 1'b1 || issue_rob !== 3'd5 || rs_full !== 1'b0) begin
            errors++;
            $display("FAIL full_issue1: valid=%0b rob=%0d full=%0b want 1/5/0",
                     issue_valid, issue_rob, rs_full); end
        for (int i = 2; i < 4; i++) begin
            step();
            checks++; if (issue_valid !== 1'b1 || issue_rob !== RW'(4 + i)) begin errors++;
                $display("FAIL full_issue%0d: valid=%0b rob=%0d want 1/%0d",
                         i, issue_valid, issue_rob, 4 + i); end
        end
        step();
        checks++; if (issue_valid !== 1'b0) begin errors++;
            $display("FAIL full_drain: got %0b want 0", issue_valid); end
        set_cdb(1, 3, 32'h33);
        step();
        set_cdb(0, 0, 0);
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rob !== 3'd2 || issue_pc !== 32'h500) begin
            errors++;
            $display("FAIL full_late_disp: valid=%0b rob=%0d pc=%0h want 1/2/500",
                     issue_valid, issue_rob, issue_pc); end
        checks++; if (issue_src1 !== 32'h33 || issue_src2 !== 32'h22) begin errors++;
            $display("FAIL full_late_srcs: got %0h/%0h want 33/22", issue_src1, issue_src2); end
        step();
        checks++; if (issue_valid !== 1'b0) begin errors++;
            $display("FAIL full_no_dup: got %0b want 0", issue_valid); end
    endtask

    task automatic test_enable();
        set_disp(32'h600, 4'h6, 0, 1, 0, 0, 9, 0, 0, 10);
        step();
        cpu_en = 1'b0;
        set_disp(32'h640, 4'h6, 0, 2, 0, 0, 1, 0, 0, 1);
        step();
        step();
        checks++; if (issue_valid !== 1'b0) begin errors++;
            $display("FAIL en_frozen_no_issue: got %0b want 0", issue_valid); end
        cpu_en = 1'b1;
        disp_valid = 1'b0;
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rob !== 3'd1 || issue_src1 !== 32'd9) begin
            errors++;
            $display("FAIL en_resume_issue: valid=%0b rob=%0d s1=%0d want 1/1/9",
                     issue_valid, issue_rob, issue_src1); end
        cpu_en = 1'b0;
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rob !== 3'd1) begin errors++;
            $display("FAIL en_hold_issue_valid: valid=%0b rob=%0d want 1/1",
                     issue_valid, issue_rob); end
        cpu_en = 1'b1;
        step();
        checks++; if (issue_valid !== 1'b0) begin errors++;
            $display("FAIL en_ignored_disp: got %0b want 0", issue_valid); end
    endtask

    task automatic test_flush();
        set_disp(32'h700, 4'h7, 0, 1, 1, 7, 0, 0, 0, 0);
        step();
        set_disp(32'h704, 4'h7, 0, 2, 1, 7, 0, 0, 0, 0);
        step();
        set_disp(32'h708, 4'h7, 0, 4, 0, 0, 1, 0, 0, 2);
        step();
        set_disp(32'h70C, 4'h7, 0, 3, 1, 7, 0, 0, 0, 0);
        step();
        checks++; if (issue_valid !== 1'b1 || issue_rob !== 3'd4) begin errors++;
            $display("FAIL flush_pre_issue: valid=%0b rob=%0d want 1/4", issue_valid, issue_rob);
        end
        rs_flush = 1'b1;
        set_disp(32'h710, 4'h7, 0, 5, 0, 0, 1, 0, 0, 1);
        set_cdb(1, 7, 32'h77);
        step();
        rs_flush = 1'b0;
        disp_valid = 1'b0;
        checks++; if (issue_valid !== 1'b0 || rs_full !== 1'b0) begin errors++;
            $display("FAIL flush_clear: valid=%0b full=%0b want 0/0", issue_valid, rs_full); end
        step();
        set_cdb(0, 0, 0);
        step();
        checks++; if (issue_valid !== 1'b0) begin errors++;
            $display("FAIL flush_no_survivor: got %0b want 0", issue_valid); end
    endtask

    task automatic test_mid_reset();
        set_disp(32'h800, 4'h8, 0, 1, 0, 0, 4, 0, 0, 4);
        step();
        set_disp(32'h804, 4'h8, 0, 2, 1, 6, 0, 0, 0, 0);
        step();
        disp_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0 || issue_rob !== 3'd0 || issue_src1 !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_async: valid=%0b rob=%0d s1=%0d want 0/0/0",
                     issue_valid, issue_rob, issue_src1); end
        #1 rst_n = 1'b1;
        set_cdb(1, 6, 32'h66);
        step();
        set_cdb(0, 0, 0);
        step();
        checks++; if (issue_valid !== 1'b0 || rs_full !== 1'b0) begin errors++;
            $display("FAIL mid_reset_discard: valid=%0b full=%0b want 0/0", issue_valid, rs_full);
        end
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_wakeup_bypass();
        test_back_to_back();
        test_full();
        test_enable();
        test_flush();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
